draw_arbiter: RTL and testbench

- Parametrised pixel-plot arbiter for the 160x120, 3-bit-colour VGA path.
- Generalises the fixed 4-way drawable multiplexer to NUM_CLIENTS drawing engines: tile drawer, background, homescreen, gameover, and any added later.
- Grants the VGA plot port to one client for a whole draw job using a req/grant/done handshake.
- Supports fixed-priority or round-robin arbitration, registers the winning pixel stream, and aborts hung jobs with a watchdog.

---
 rtl/draw_pkg.sv | 28 ++
 rtl/draw_arbiter_rr_picker.sv | 50 +++++
 rtl/draw_arbiter.sv | 142 ++++++++++++++
 tb/tb_draw_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : draw_pkg
// Description : Shared constants for the 160x120 3-bit-colour VGA draw path:
//               screen size, coordinate widths, client indices, FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package draw_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;

    localparam int DRAW_X_W   = 8;
    localparam int DRAW_Y_W   = 7;
    localparam int DRAW_COL_W = 3;

    localparam int CL_TILES    = 0;
    localparam int CL_BG       = 1;
    localparam int CL_HOME     = 2;
    localparam int CL_GAMEOVER = 3;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_GRANT   = 2'd1;
    localparam logic [1:0] c_ST_ACTIVE  = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/draw_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational request picker, rotating or fixed priority;
//               returns a one-hot winner and its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import draw_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    input  logic                   i_rr_mode,
    output logic [NUM_CLIENTS-1:0] o_onehot,
    output logic [IDX_W-1:0]       o_idx
);

    localparam logic [NUM_CLIENTS-1:0] c_ONE = NUM_CLIENTS'(1);

    logic [NUM_CLIENTS-1:0] w_mask;
    logic [NUM_CLIENTS-1:0] w_upper;
    logic [NUM_CLIENTS-1:0] w_cand;
    logic [NUM_CLIENTS-1:0] w_onehot;
    logic [IDX_W-1:0]       w_idx;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_mask[i] = i_rr_mode && (i >= int'(i_ptr));
        end
        // Requests at or above the pointer take precedence; otherwise wrap.
        w_upper  = i_req & w_mask;
        w_cand   = (|w_upper) ? w_upper : i_req;
        w_onehot = w_cand & (~w_cand + c_ONE);
        w_idx    = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_onehot[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    assign o_onehot = w_onehot;
    assign o_idx    = w_idx;

endmodule
`default_nettype wire

// File: rtl/draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : draw_arbiter
// Description : Grants the VGA plot port to one drawing client per job and
//               registers its pixel stream; a watchdog aborts hung jobs.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int X_W            = draw_pkg::DRAW_X_W,
    parameter int Y_W            = draw_pkg::DRAW_Y_W,
    parameter int COL_W          = draw_pkg::DRAW_COL_W,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 19200
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CLIENTS-1:0]       req,
    input  logic [NUM_CLIENTS-1:0]       plot_in,
    input  logic [NUM_CLIENTS-1:0]       done_in,
    input  logic [NUM_CLIENTS*X_W-1:0]   x_in,
    input  logic [NUM_CLIENTS*Y_W-1:0]   y_in,
    input  logic [NUM_CLIENTS*COL_W-1:0] col_in,
    output logic [NUM_CLIENTS-1:0]       grant,
    output logic [$clog2(NUM_CLIENTS)-1:0] grant_id,
    output logic                         busy,
    output logic [X_W-1:0]               x_out,
    output logic [Y_W-1:0]               y_out,
    output logic [COL_W-1:0]             col_out,
    output logic                         plot_out,
    output logic                         timeout_err
);

    import draw_pkg::*;

    localparam int IDX_W = $clog2(NUM_CLIENTS);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WD_W-1:0]  c_WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0]  c_WD_ONE   = WD_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_CLIENTS - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);
    localparam logic             c_RR_MODE  = (ROUND_ROBIN != 0);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [WD_W-1:0]  r_wdog;

    logic [NUM_CLIENTS-1:0] w_pick_oh;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_sel_req;
    logic                   w_sel_plot;
    logic                   w_sel_done;
    logic [X_W-1:0]         w_sel_x;
    logic [Y_W-1:0]         w_sel_y;
    logic [COL_W-1:0]       w_sel_col;
    logic [IDX_W-1:0]       w_ptr_next;

    rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .i_rr_mode (c_RR_MODE),
        .o_onehot  (w_pick_oh),
        .o_idx     (w_pick_idx)
    );

    // grant_id doubles as the owner index for the whole job.
    assign w_sel_req  = req[grant_id];
    assign w_sel_plot = plot_in[grant_id];
    assign w_sel_done = done_in[grant_id];
    assign w_sel_x    = x_in[int'(grant_id)*X_W +: X_W];
    assign w_sel_y    = y_in[int'(grant_id)*Y_W +: Y_W];
    assign w_sel_col  = col_in[int'(grant_id)*COL_W +: COL_W];
    assign w_ptr_next = (grant_id == c_IDX_LAST) ? '0 : grant_id + c_IDX_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_ptr       <= '0;
            r_wdog      <= '0;
            grant       <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            col_out     <= '0;
            plot_out    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    plot_out <= 1'b0;
                    if (|req) begin
                        grant    <= w_pick_oh;
                        grant_id <= w_pick_idx;
                        busy     <= 1'b1;
                        r_state  <= c_ST_GRANT;
                    end
                end
                c_ST_GRANT: begin
                    r_wdog  <= '0;
                    r_state <= c_ST_ACTIVE;
                end
                c_ST_ACTIVE: begin
                    x_out    <= w_sel_x;
                    y_out    <= w_sel_y;
                    col_out  <= w_sel_col;
                    plot_out <= w_sel_plot;
                    if (r_wdog != '1) begin
                        r_wdog <= r_wdog + c_WD_ONE;
                    end
                    // done beats a coincident timeout, so it is tested first.
                    if (w_sel_done || !w_sel_req) begin
                        grant   <= '0;
                        r_state <= c_ST_RELEASE;
                    end else if (r_wdog == c_WD_LAST) begin
                        grant       <= '0;
                        timeout_err <= 1'b1;
                        r_state     <= c_ST_RELEASE;
                    end
                end
                c_ST_RELEASE: begin
                    plot_out <= 1'b0;
                    busy     <= 1'b0;
                    if (c_RR_MODE) begin
                        r_ptr <= w_ptr_next;
                    end
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_arbiter
// Description : Scoreboard bench for draw_arbiter; one rotating-priority and
//               one fixed-priority instance share the same client stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_arbiter;

    localparam int N   = 4;
    localparam int XW  = 8;
    localparam int YW  = 7;
    localparam int CW  = 3;
    localparam int TMO = 8;

    // Job phases of the reference model.
    localparam int P_WAIT   = 0;
    localparam int P_ISSUED = 1;
    localparam int P_DRAW   = 2;
    localparam int P_DRAIN  = 3;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic [N-1:0]  req     = '0;
    logic [N-1:0]  plot_in = '0;
    logic [N-1:0]  done_in = '0;
    logic [N*XW-1:0] x_in  = '0;
    logic [N*YW-1:0] y_in  = '0;
    logic [N*CW-1:0] col_in = '0;

    logic [N-1:0]  grant_a [2];
    logic [1:0]    gid_a   [2];
    logic          busy_a  [2];
    logic [XW-1:0] xo_a    [2];
    logic [YW-1:0] yo_a    [2];
    logic [CW-1:0] co_a    [2];
    logic          plot_a  [2];
    logic          tmo_a   [2];

    always #10 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        draw_arbiter #(
            .NUM_CLIENTS    (N),
            .X_W            (XW),
            .Y_W            (YW),
            .COL_W          (CW),
            .ROUND_ROBIN    ((g == 0) ? 1 : 0),
            .TIMEOUT_CYCLES (TMO)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .req         (req),
            .plot_in     (plot_in),
            .done_in     (done_in),
            .x_in        (x_in),
            .y_in        (y_in),
            .col_in      (col_in),
            .grant       (grant_a[g]),
            .grant_id    (gid_a[g]),
            .busy        (busy_a[g]),
            .x_out       (xo_a[g]),
            .y_out       (yo_a[g]),
            .col_out     (co_a[g]),
            .plot_out    (plot_a[g]),
            .timeout_err (tmo_a[g])
        );
    end

    // ---------------- reference model ----------------
    int            m_phase [2];
    int            m_owner [2];
    int            m_ptr   [2];
    int            m_age   [2];
    logic          m_busy  [2];
    logic          m_tmo   [2];
    logic [N-1:0]  m_gnt   [2];
    logic [1:0]    m_gid   [2];
    logic [XW-1:0] m_x     [2];
    logic [YW-1:0] m_y     [2];
    logic [CW-1:0] m_c     [2];
    int            exp_gnt [2][$];
    logic [XW+YW+CW-1:0] exp_pix [2][$];

    function automatic int pick(input logic [N-1:0] r, input int p, input bit rr);
        int i;
        for (int k = 0; k < N; k++) begin
            i = rr ? (p + k) % N : k;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int o;
            m_tmo[k] = 1'b0;
            if (reset) begin
                m_phase[k] = P_WAIT;
                m_owner[k] = 0;
                m_ptr[k]   = 0;
                m_age[k]   = 0;
                m_busy[k]  = 1'b0;
                m_gnt[k]   = '0;
                m_gid[k]   = '0;
                m_x[k]     = '0;
                m_y[k]     = '0;
                m_c[k]     = '0;
                exp_gnt[k].delete();
                exp_pix[k].delete();
            end else begin
                o = m_owner[k];
                case (m_phase[k])
                    P_WAIT: begin
                        if (req != '0) begin
                            m_owner[k] = pick(req, m_ptr[k], k == 0);
                            exp_gnt[k].push_back(m_owner[k]);
                            m_gnt[k]   = N'(1 << m_owner[k]);
                            m_gid[k]   = 2'(m_owner[k]);
                            m_busy[k]  = 1'b1;
                            m_phase[k] = P_ISSUED;
                        end
                    end
                    P_ISSUED: begin
                        m_age[k]   = 0;
                        m_phase[k] = P_DRAW;
                    end
                    P_DRAW: begin
                        m_x[k] = x_in[o*XW +: XW];
                        m_y[k] = y_in[o*YW +: YW];
                        m_c[k] = col_in[o*CW +: CW];
                        if (plot_in[o]) exp_pix[k].push_back({m_x[k], m_y[k], m_c[k]});
                        m_age[k] = m_age[k] + 1;
                        if (done_in[o] || !req[o]) begin
                            m_gnt[k]   = '0;
                            m_phase[k] = P_DRAIN;
                        end else if (m_age[k] == TMO) begin
                            m_gnt[k]   = '0;
                            m_tmo[k]   = 1'b1;
                            m_phase[k] = P_DRAIN;
                        end
                    end
                    default: begin
                        if (k == 0) m_ptr[k] = (o + 1) % N;
                        m_busy[k]  = 1'b0;
                        m_phase[k] = P_WAIT;
                    end
                endcase
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;
    bit   end_req = 1'b0;
    logic [N-1:0] prev_gnt [2] = '{default: '0};
    int   e;
    logic [XW+YW+CW-1:0] pe;

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, k, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                if (grant_a[k] != '0 && prev_gnt[k] == '0) begin
                    if (exp_gnt[k].size() == 0) begin
                        chk("grant_event_unexpected", k, 32'(grant_a[k]), 32'h0);
                    end else begin
                        e = exp_gnt[k].pop_front();
                        chk("grant_event_id", k, 32'(gid_a[k]), 32'(e));
                    end
                end
                prev_gnt[k] = grant_a[k];
                if (plot_a[k] !== 1'b0) begin
                    if (exp_pix[k].size() == 0) begin
                        chk("pixel_unexpected", k, 32'(plot_a[k]), 32'h0);
                    end else begin
                        pe = exp_pix[k].pop_front();
                        chk("pixel_xyc", k, 32'({xo_a[k], yo_a[k], co_a[k]}), 32'(pe));
                    end
                end
                chk("grant", k, 32'(grant_a[k]), 32'(m_gnt[k]));
                chk("grant_id", k, 32'(gid_a[k]), 32'(m_gid[k]));
                chk("busy", k, 32'(busy_a[k]), 32'(m_busy[k]));
                chk("timeout_err", k, 32'(tmo_a[k]), 32'(m_tmo[k]));
                chk("xyc_hold", k, 32'({xo_a[k], yo_a[k], co_a[k]}), 32'({m_x[k], m_y[k], m_c[k]}));
            end
        end
        if (end_req) begin
            end_req = 1'b0;
            for (int k = 0; k < 2; k++) begin
                chk("pending_grants", k, 32'(exp_gnt[k].size()), 32'h0);
                chk("pending_pixels", k, 32'(exp_pix[k].size()), 32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_pix(input int c, input int x, input int y, input int col);
        x_in[c*XW +: XW]   = XW'(x);
        y_in[c*YW +: YW]   = YW'(y);
        col_in[c*CW +: CW] = CW'(col);
    endtask

    initial begin
        reset = 1'b1;
        step(2);
        mon_en = 1'b1;
        step(1);
        reset = 1'b0;
        step(2);

        // Single job from client 2.
        set_pix(2, 10, 20, 5);
        req = 4'b0100;
        step(2);
        plot_in = 4'b0100;
        step(3);
        plot_in = '0;
        done_in = 4'b0100;
        step(1);
        done_in = '0;
        req     = '0;
        step(4);

        // All clients requesting, one plot then done per job, from a fresh pointer.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_pix(i, i + 1, i + 2, i);
        req     = 4'b1111;
        plot_in = 4'b1111;
        done_in = 4'b1111;
        step(20);
        req     = '0;
        plot_in = '0;
        done_in = '0;
        step(4);

        // Client 3 plots while client 1 owns the port.
        set_pix(1, 7, 8, 2);
        set_pix(3, 99, 99, 7);
        req     = 4'b0010;
        plot_in = 4'b1010;
        step(8);
        done_in = 4'b0010;
        step(1);
        done_in = '0;
        req     = '0;
        plot_in = '0;
        step(4);

        // Hung jobs: clients 0 and 1 never finish.
        req = 4'b0011;
        for (int i = 0; i < 30; i++) begin
            plot_in = N'($urandom);
            x_in    = (N*XW)'($urandom);
            step(1);
        end
        req     = '0;
        plot_in = '0;
        step(5);

        // done on the last allowed active cycle.
        req = 4'b0001;
        step(9);
        done_in = 4'b0001;
        step(1);
        done_in = '0;
        req     = '0;
        step(4);

        // Reset in the middle of an active job with plotting.
        set_pix(2, 33, 44, 6);
        req     = 4'b0100;
        plot_in = 4'b0100;
        step(5);
        reset = 1'b1;
        step(1);
        reset   = 1'b0;
        plot_in = '0;
        req     = '0;
        step(3);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
                done_in[b] = ($urandom_range(0, 9) == 0);
            end
            plot_in = N'($urandom);
            x_in    = (N*XW)'($urandom);
            y_in    = (N*YW)'($urandom);
            col_in  = (N*CW)'($urandom);
            step(1);
        end
        req     = '0;
        plot_in = '0;
        done_in = '0;
        step(6);

        end_req = 1'b1;
        step(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
